// File: rtl/mii_rx_frame_gen.sv
// mii_rx_frame_gen: turns a valid/ready byte stream into complete MII receive
// frames (preamble, SFD, payload, zero padding, CRC32 FCS, inter-frame gap).
// One nibble is emitted per clk; every MII output is registered.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_IDLE     | waiting for s_tvalid, MII idle
// ST_PREAMBLE | driving 0x5 nibbles
// ST_SFD      | driving 0xD, first payload byte accepted
// ST_DATA0    | low nibble of held byte
// ST_DATA1    | high nibble of held byte, next byte accepted unless last
// ST_PAD0     | low nibble of a zero pad byte
// ST_PAD1     | high nibble of a zero pad byte
// ST_FCS      | eight nibbles of the inverted CRC, LS nibble first
// ST_IFG      | inter-frame gap, MII idle
// ST_DROP     | after starvation: swallow beats up to tlast, MII idle
module mii_rx_frame_gen #(
    parameter int IFG_NIBBLES      = 24,
    parameter int MIN_PAYLOAD      = 60,
    parameter int PREAMBLE_NIBBLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic [3:0]  phy_rxd,
    output logic        phy_rx_dv,
    output logic        phy_rx_er,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_count
);

    localparam int BC_W = $clog2(MIN_PAYLOAD + 1);
    // Timer covers preamble, FCS and IFG lengths; all parameters stay below 256.
    localparam int TC_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA0, ST_DATA1,
        ST_PAD0, ST_PAD1, ST_FCS, ST_IFG, ST_DROP
    } state_t;

    state_t            state;
    logic [TC_W-1:0]   timer;
    logic [BC_W-1:0]   byte_cnt;
    logic [BC_W-1:0]   byte_cnt_inc;
    logic [31:0]       crc;
    logic [3:0]        hold_hi;
    logic              hold_last;
    logic              hold_user;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Ready depends on state only, so it drops with the async reset.
    assign s_tready = (state == ST_SFD) || (state == ST_DROP) ||
                      ((state == ST_DATA1) && !hold_last);

    // Payload byte count saturates once the minimum frame size is reached.
    assign byte_cnt_inc = (byte_cnt == BC_W'(MIN_PAYLOAD)) ? byte_cnt : byte_cnt + BC_W'(1);

    // Frame sequencer; outputs are loaded together with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            byte_cnt    <= '0;
            crc         <= '1;
            hold_hi     <= '0;
            hold_last   <= 1'b0;
            hold_user   <= 1'b0;
            phy_rxd     <= '0;
            phy_rx_dv   <= 1'b0;
            phy_rx_er   <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
            frame_count <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                ST_IDLE, ST_IFG: begin
                    if (state == ST_IFG && timer != '0) begin
                        timer <= timer - TC_W'(1);
                    end else if (s_tvalid) begin
                        // IFG falls straight into the next preamble to keep the gap exact.
                        state     <= ST_PREAMBLE;
                        timer     <= TC_W'(PREAMBLE_NIBBLES - 1);
                        crc       <= '1;
                        byte_cnt  <= '0;
                        phy_rxd   <= 4'h5;
                        phy_rx_dv <= 1'b1;
                        phy_rx_er <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (timer == '0) begin
                        state   <= ST_SFD;
                        phy_rxd <= 4'hD;
                    end else begin
                        timer <= timer - TC_W'(1);
                    end
                end
                ST_SFD, ST_DATA1: begin
                    if (state == ST_DATA1 && hold_last) begin
                        phy_rx_er <= 1'b0;
                        if (byte_cnt < BC_W'(MIN_PAYLOAD)) begin
                            state    <= ST_PAD0;
                            phy_rxd  <= 4'h0;
                            crc      <= crc_byte(crc, 8'h00);
                            byte_cnt <= byte_cnt_inc;
                        end else begin
                            state   <= ST_FCS;
                            timer   <= TC_W'(7);
                            phy_rxd <= ~crc[3:0];
                            crc     <= crc >> 4;
                        end
                    end else if (s_tvalid) begin
                        state     <= ST_DATA0;
                        phy_rxd   <= s_tdata[3:0];
                        phy_rx_er <= s_tuser;
                        hold_hi   <= s_tdata[7:4];
                        hold_last <= s_tlast;
                        hold_user <= s_tuser;
                        crc       <= crc_byte(crc, s_tdata);
                        byte_cnt  <= byte_cnt_inc;
                    end else begin
                        // Starved mid-frame: one poisoned nibble, then discard the rest.
                        state     <= ST_DROP;
                        phy_rxd   <= 4'h0;
                        phy_rx_er <= 1'b1;
                        underrun  <= 1'b1;
                    end
                end
                ST_DATA0: begin
                    state     <= ST_DATA1;
                    phy_rxd   <= hold_hi;
                    phy_rx_er <= hold_user;
                end
                ST_PAD0: begin
                    state   <= ST_PAD1;
                    phy_rxd <= 4'h0;
                end
                ST_PAD1: begin
                    if (byte_cnt < BC_W'(MIN_PAYLOAD)) begin
                        state    <= ST_PAD0;
                        phy_rxd  <= 4'h0;
                        crc      <= crc_byte(crc, 8'h00);
                        byte_cnt <= byte_cnt_inc;
                    end else begin
                        state   <= ST_FCS;
                        timer   <= TC_W'(7);
                        phy_rxd <= ~crc[3:0];
                        crc     <= crc >> 4;
                    end
                end
                ST_FCS: begin
                    if (timer == '0) begin
                        state       <= ST_IFG;
                        timer       <= TC_W'(IFG_NIBBLES - 1);
                        phy_rxd     <= 4'h0;
                        phy_rx_dv   <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        timer   <= timer - TC_W'(1);
                        phy_rxd <= ~crc[3:0];
                        crc     <= crc >> 4;
                    end
                end
                ST_DROP: begin
                    phy_rxd   <= 4'h0;
                    phy_rx_dv <= 1'b0;
                    phy_rx_er <= 1'b0;
                    if (s_tvalid && s_tlast) begin
                        state <= ST_IFG;
                        timer <= TC_W'(IFG_NIBBLES - 1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_rx_frame_gen.sv
// Testbench for mii_rx_frame_gen: a reference model expands each frame into the
// expected nibble stream, a negedge monitor pops and compares whatever the DUT
// drives while phy_rx_dv is high, and checks gaps, frame_count and the CRC residue.
module tb_mii_rx_frame_gen;

    localparam logic [31:0] POLY    = 32'hEDB8_8320;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [3:0]  phy_rxd;
    logic        phy_rx_dv;
    logic        phy_rx_er;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_count;

    mii_rx_frame_gen dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .phy_rxd(phy_rxd), .phy_rx_dv(phy_rx_dv), .phy_rx_er(phy_rx_er),
        .busy(busy), .underrun(underrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic       er;
        logic       crc_nib;
        logic       last;
        logic       good;
        logic       und;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fr_data[$];
    logic       fr_user[$];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_frames = 0;
    int exp_und = 0;
    int und_cnt = 0;
    bit mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] r = c;
        for (int i = 0; i < 4; i++) r = (r[0] ^ n[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    task automatic push_nib(input logic [3:0] n, input logic er, input logic cn,
                            input logic last, input logic good, input logic und, input int gap);
        exp_t e;
        e.nib = n; e.er = er; e.crc_nib = cn; e.last = last;
        e.good = good; e.und = und; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Expected MII nibble stream for fr_data/fr_user. und_after >= 0 models starvation
    // after that many bytes; gap >= 0 demands that exact idle gap before this frame.
    task automatic push_frame(input int gap, input int und_after);
        int          len = fr_data.size();
        int          nbytes;
        logic [31:0] c = 32'hFFFF_FFFF;
        logic [31:0] f;
        logic [7:0]  b;
        logic        u;
        push_nib(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, gap);
        for (int i = 1; i < 15; i++) push_nib(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        push_nib(4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        if (und_after >= 0) nbytes = und_after;
        else nbytes = (len < 60) ? 60 : len;
        for (int i = 0; i < nbytes; i++) begin
            b = (i < len) ? fr_data[i] : 8'h00;
            u = (i < len) ? fr_user[i] : 1'b0;
            c = crc_upd(c, b);
            push_nib(b[3:0], u, 1'b1, 1'b0, 1'b0, 1'b0, -1);
            push_nib(b[7:4], u, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        end
        if (und_after >= 0) begin
            push_nib(4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        end else begin
            f = ~c;
            for (int k = 0; k < 8; k++)
                push_nib(f[4*k +: 4], 1'b0, 1'b1, k == 7, 1'b1, 1'b0, -1);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
        logic rdy;
        int   t = 0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        forever begin
            rdy = s_tready;
            @(negedge clk);
            if (rdy) break;
            t++;
            if (t > 2000) begin
                note_fail("beat accept timeout");
                break;
            end
        end
    endtask

    task automatic send_frame(input bit keep);
        for (int i = 0; i < fr_data.size(); i++)
            send_beat(fr_data[i], i == fr_data.size() - 1, fr_user[i]);
        if (!keep) begin
            s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        end
    endtask

    task automatic set_frame(input int len, input int mode);
        fr_data.delete(); fr_user.delete();
        for (int i = 0; i < len; i++) begin
            fr_data.push_back((mode == 0) ? 8'(i) : 8'($urandom_range(0, 255)));
            fr_user.push_back(1'b0);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain leftover nibbles", exp_q.size(), 0);
    endtask

    // Monitor: compares every dv cycle against the scoreboard head.
    int          gap = 0;
    bit          prev_dv = 1'b0;
    bit          have_prev = 1'b0;
    logic [31:0] res = 32'hFFFF_FFFF;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_dv = 1'b0; have_prev = 1'b0; gap = 0;
        end else if (mon_en) begin
            if (underrun) und_cnt++;
            if (phy_rx_dv) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected dv");
                end else begin
                    e = exp_q.pop_front();
                    if (!prev_dv) begin
                        res = 32'hFFFF_FFFF;
                        if (have_prev) begin
                            if (e.gap >= 0) chk("ifg exact", gap, e.gap);
                            else chk("ifg min", gap >= 24, 1);
                        end
                    end
                    chk("rxd", phy_rxd, e.nib);
                    chk("rx_er", phy_rx_er, e.er);
                    chk("underrun", underrun, e.und);
                    chk("busy in frame", busy, 1);
                    if (e.crc_nib) res = crc_nibble(res, phy_rxd);
                    if (e.last && e.good) begin
                        chk("crc residue", res, RESIDUE);
                        exp_frames++;
                    end
                end
                gap = 0;
            end else begin
                if (prev_dv) begin
                    chk("frame_count", frame_count, exp_frames);
                    have_prev = 1'b1;
                end
                gap++;
            end
            prev_dv = phy_rx_dv;
        end
    end

    initial begin
        int len, idle;
        rst = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rxd", phy_rxd, 0);
        chk("reset dv", phy_rx_dv, 0);
        chk("reset er", phy_rx_er, 0);
        chk("reset tready", s_tready, 0);
        chk("reset busy", busy, 0);
        chk("reset underrun", underrun, 0);
        chk("reset frame_count", frame_count, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 60 bytes 0x00..0x3B, no padding.
        set_frame(60, 0);
        push_frame(-1, -1);
        send_frame(0);
        repeat (5) @(negedge clk);

        // Short frame, padded to 60 bytes.
        fr_data = '{8'h12, 8'h35, 8'h8A, 8'hE8};
        fr_user = '{1'b0, 1'b0, 1'b0, 1'b0};
        push_frame(-1, -1);
        send_frame(0);
        wait_drain();

        // Two back-to-back 64-byte frames: gap must be exactly the IFG.
        set_frame(64, 1);
        push_frame(-1, -1);
        send_frame(1);
        set_frame(64, 1);
        push_frame(24, -1);
        send_frame(0);

        // Error-inject on byte 5 only.
        set_frame(64, 1);
        fr_user[5] = 1'b1;
        push_frame(-1, -1);
        send_frame(0);

        // Starvation after 11 bytes of a 64-byte frame.
        set_frame(64, 1);
        push_frame(-1, 11);
        exp_und++;
        for (int i = 0; i < 11; i++) send_beat(fr_data[i], 1'b0, 1'b0);
        s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 11; i < 64; i++) send_beat(fr_data[i], i == 63, 1'b0);
        s_tvalid = 1'b0; s_tlast = 1'b0;

        // Single-byte frame and randomized traffic.
        set_frame(1, 1);
        push_frame(-1, -1);
        send_frame(0);
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 80);
            set_frame(len, 1);
            if ($urandom_range(0, 3) == 0) fr_user[$urandom_range(0, len - 1)] = 1'b1;
            push_frame(-1, -1);
            send_frame(0);
            idle = $urandom_range(0, 40);
            repeat (idle) @(negedge clk);
        end
        wait_drain();
        chk("underrun pulses", und_cnt, exp_und);

        // Reset while in the data phase, then a fresh frame.
        mon_en = 1'b0;
        set_frame(20, 1);
        for (int i = 0; i < 6; i++) send_beat(fr_data[i], 1'b0, 1'b0);
        @(negedge clk);
        chk("tready before reset", s_tready, 1);
        chk("dv before reset", phy_rx_dv, 1);
        #2 rst = 1'b0;
        #1;
        chk("async reset dv", phy_rx_dv, 0);
        chk("async reset er", phy_rx_er, 0);
        chk("async reset busy", busy, 0);
        chk("async reset tready", s_tready, 0);
        chk("async reset frame_count", frame_count, 0);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        set_frame(30, 1);
        push_frame(-1, -1);
        send_frame(0);
        wait_drain();
        chk("final frame_count", frame_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mii_rx_frame_gen.md
Name: mii_rx_frame_gen

Overview:
- Upstream stage for the fpga_core MII receive port. It turns a byte stream (valid/ready, tlast/tuser) into a complete 100BASE-T MII receive frame on phy_rxd/phy_rx_dv/phy_rx_er.
- Each frame gets preamble, SFD, padding to the Ethernet minimum and a CRC32 FCS, followed by an inter-frame gap.
- It lets bench or loopback logic drive the DUT with legal frames instead of static nibbles.

Parameters:
- IFG_NIBBLES, 24, number of idle cycles (dv=0) after each frame (12 byte-times).
- MIN_PAYLOAD, 60, minimum bytes before FCS; short frames are zero-padded up to this.
- PREAMBLE_NIBBLES, 15, count of 0x5 nibbles sent before the SFD nibble.

Ports:
- clk  in  1  nibble clock; phy_rx_clk domain, one nibble per cycle.
- rst  in  1  asynchronous, active-low reset.
- s_tdata  in  8  payload byte (destination MAC first).
- s_tvalid  in  1  byte valid.
- s_tready  out  1  byte accepted when s_tvalid&&s_tready.
- s_tlast  in  1  last payload byte of frame.
- s_tuser  in  1  error-inject flag for this byte.
- phy_rxd  out  4  MII receive nibble.
- phy_rx_dv  out  1  MII data valid.
- phy_rx_er  out  1  MII receive error.
- busy  out  1  high in any state except IDLE.
- underrun  out  1  one-cycle pulse on input starvation mid-frame.
- frame_count  out  16  completed (non-aborted) frames; wraps 0xFFFF->0.

Behaviour:
- Reset (rst=0, async) values:
  - phy_rxd=0, phy_rx_dv=0, phy_rx_er=0
  - s_tready=0, busy=0, underrun=0, frame_count=0
  - FSM=IDLE, CRC=0xFFFFFFFF
- All MII outputs are registered.
- IDLE: s_tready=0. When s_tvalid=1, go to PREAMBLE. phy_rx_dv rises on the next clock edge (latency 1).
- PREAMBLE:
  - Drive PREAMBLE_NIBBLES cycles of rxd=0x5, dv=1.
  - Then SFD.
- SFD:
  - Drive rxd=0xD, dv=1.
  - s_tready=1 combinationally; capture the first byte with its tlast/tuser.
  - Then DATA phase0.
- DATA (2 cycles per byte):
  - phase0 drives the low nibble; phase1 drives the high nibble.
  - rx_er=captured tuser on both nibbles.
  - The CRC update for the byte is applied once per byte.
  - In phase1: if the captured byte is not last, s_tready=1 and the next byte is captured.
  - Underrun: if s_tvalid=0 in phase1 (not last), that is an underrun. Next cycle drives dv=1, rx_er=1, rxd=0 for one nibble and pulses underrun. Then go to DROP.
  - Byte counter saturates at MIN_PAYLOAD.
  - After the last byte's phase1: go to PAD if count<MIN_PAYLOAD, else FCS.
- PAD:
  - Emit 0x00 bytes (2 nibbles each, CRC updated) until count=MIN_PAYLOAD.
  - Then FCS.
- FCS:
  - 8 nibbles of ~CRC, least-significant nibble first.
  - CRC is reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at PREAMBLE entry.
  - rx_er=0 throughout.
  - Then increment frame_count and go to IFG.
- IFG:
  - dv=0, rxd=0, s_tready=0 for IFG_NIBBLES cycles.
  - Then IDLE; back-to-back frames therefore start exactly IFG_NIBBLES+1 cycles after the last FCS nibble.
- DROP:
  - dv=0, s_tready=1; discard beats until the beat with tlast is accepted.
  - Then IFG. frame_count is not incremented.
- DATA holding reg is one byte; no other buffering. A 1-byte frame pads 59 bytes.
- tlast on an SFD-captured byte is legal (single-byte frame).
- tuser asserted on a padded or FCS nibble is impossible by construction.
- Reset mid-frame: outputs drop immediately (async), FSM=IDLE, the partial frame is lost, and frame_count is cleared.

Test Plan:
- 60-byte frame bytes 0x00..0x3B, tvalid always 1 -> dv high for 16+120+8=144 cycles:
  - first 15 nibbles 0x5, then 0xD;
  - first data nibbles 0x0,0x0,0x1,0x0;
  - CRC32 recomputed over data+FCS nibbles gives residue 0xDEBB20E3;
  - frame_count=1.
- 4-byte frame 0x12,0x35,0x8A,0xE8:
  - nibbles 2,1,5,3,A,8,8,E;
  - then 56 padded bytes (112 zero nibbles), 8 FCS nibbles;
  - dv high 144 cycles total.
- Two back-to-back 64-byte frames -> dv low for exactly 24 cycles between them; second frame starts on the cycle after IFG ends; frame_count=2.
- Drop tvalid for 3 cycles after byte 10 of a 64-byte frame:
  - underrun pulses once;
  - one nibble with dv=1, rx_er=1;
  - remaining beats consumed up to tlast with dv=0;
  - frame_count unchanged.
- tuser=1 on byte 5 -> rx_er=1 on exactly that byte's two nibbles; frame otherwise normal with a valid FCS.
- Assert rst=0 during DATA -> phy_rx_dv, phy_rx_er, busy, s_tready go 0 without a clock edge. After release, a new frame starts with a full preamble.
